fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the PSRV32 pipeline. Holds the program counter, issues in-order word requests to instruction memory, buffers returned instructions with their PCs, and presents them to the fetch-decode pipeline register. It handles decode-side back-pressure and redirects from branch/jump resolution, and discards stale in-flight responses after a redirect.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- BUF_DEPTH, 4, instruction buffer entries; power of two, ≥2; ≥3 sustains 1 instr/cycle

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; asynchronous, active-high
- stall_i  input  1  decode cannot accept this cycle
- redirect_i  input  1  control-flow change; flush and refetch
- redirect_pc_i  input  32  new PC; bits [1:0] ignored and treated as 0
- imem_req_o  output  1  request valid
- imem_addr_o  output  32  request word address (byte address, [1:0]=0)
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response valid; responses arrive in request order, ≥1 cycle after grant
- imem_rdata_i  input  32  response instruction
- f_valid_o  output  1  f_instruction_o/f_pc_o hold a valid instruction
- f_instruction_o  output  32  instruction to fetch-decode register
- f_pc_o  output  32  PC of f_instruction_o

## Operation
- State: pc register, outstanding counter (0..BUF_DEPTH), discard counter (0..BUF_DEPTH), circular buffer of BUF_DEPTH {instruction, pc} entries with rd/wr pointers and count, PC FIFO of BUF_DEPTH entries recording the address of every granted request.
- Reset values: pc=RESET_PC, all counters/pointers 0, imem_req_o=0 while rst_i high, f_valid_o=0, f_instruction_o=0, f_pc_o=0 (buffer storage reset to 0).
- Issue: imem_req_o=1 when !redirect_i and outstanding+count < BUF_DEPTH (registered values). imem_addr_o=pc. On req&&gnt: push pc to PC FIFO, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), outstanding+1.
- imem_req_o is not withdrawn and imem_addr_o not changed while waiting for grant, except on redirect.
- Response: on rvalid, pop PC FIFO, outstanding-1. If discard>0: drop data, discard-1. Else write {rdata, popped pc} to buffer at wr pointer.
- Output: f_valid_o = (count≠0) && !redirect_i; f_instruction_o/f_pc_o = buffer head. Consume (rd pointer+1, count-1) when f_valid_o && !stall_i.
- Redirect (priority over everything): buffer count and pointers cleared, pc<=redirect_pc_i & ~3, imem_req_o=0 that cycle, discard<=outstanding−(rvalid?1:0)+discard... precisely: discard<=number of requests still outstanding after this cycle's response is retired; response arriving in redirect cycle is dropped. PC FIFO entries are still popped normally for dropped responses.
- Simultaneous push and consume: count unchanged. Simultaneous grant and rvalid: outstanding unchanged.
- stall_i has no effect on issue other than via buffer credit; redirect_i overrides stall_i.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight memory responses after release are a system error (memory is reset together).

## Timing
- Request granted at cycle N, rvalid at N+L (L≥1) → f_valid_o at N+L+1.
- Zero-wait memory (gnt=1, L=1): first request cycle 0 after reset release, f_valid_o rises cycle 2, then one instruction per cycle with stall_i low and BUF_DEPTH≥3.
- Redirect at cycle R: no request at R; request to redirect target at R+1; its instruction valid at R+3 with L=1.
- Full buffer + stall: issue stops once outstanding+count=BUF_DEPTH; no response is ever lost.

## Test plan
- Reset release, RESET_PC=0, gnt=1, L=1, stall_i=0 → imem_addr_o 0,4,8,… from cycle 0; f_valid_o from cycle 2 with f_pc_o 0,4,8 and matching rdata.
- stall_i held high 10 cycles from steady state → exactly 4 instructions buffered, imem_req_o low, f_pc_o frozen; release → in-order resume, no gaps or duplicates.
- Redirect to 32'h0000_0103 with 2 responses in flight (L=3) → both dropped, imem_req_o low in redirect cycle, next addr 32'h0000_0100, first f_pc_o after redirect = 0x100.
- gnt toggling 1/0 with random L 1..4 → imem_addr_o stable while ungranted; f_pc_o sequence strictly +4, data matches address.
- pc=32'hFFFF_FFF8 → fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_i asserted mid-burst with full buffer → f_valid_o=0 and imem_req_o=0 asynchronously; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// PSRV32 instruction fetch stage: PC generation, in-order imem requests,
// response buffering with PC tagging, decode back-pressure and redirect flush.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        f_valid_o,
   output logic [31:0] f_instruction_o,
   output logic [31:0] f_pc_o
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]      pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] discard;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] pf_rd;
   logic [PTR_W-1:0] pf_wr;
   logic [31:0]      ibuf_instr [BUF_DEPTH];
   logic [31:0]      ibuf_pc    [BUF_DEPTH];
   logic [31:0]      pc_fifo    [BUF_DEPTH];

   logic [CNT_W:0]   credit;
   logic             req;
   logic             issue;
   logic             keep;
   logic             fvalid;
   logic             consume;
   logic [31:0]      rsp_pc;

   // Issue is limited so every in-flight response is guaranteed a buffer slot.
   always_comb begin
      credit  = {1'b0, outstanding} + {1'b0, count};
      req     = !rst_i && !redirect_i && (credit < (CNT_W+1)'(BUF_DEPTH));
      issue   = req && imem_gnt_i;
      rsp_pc  = pc_fifo[pf_rd];
      keep    = imem_rvalid_i && !redirect_i && (discard == '0);
      fvalid  = (count != '0) && !redirect_i;
      consume = fvalid && !stall_i;
   end

   assign imem_req_o      = req;
   assign imem_addr_o     = pc;
   assign f_valid_o       = fvalid;
   assign f_instruction_o = ibuf_instr[rd_ptr];
   assign f_pc_o          = ibuf_pc[rd_ptr];

   // Addresses of granted requests; data only, pointers live with the control state.
   always_ff @(posedge clk_i) begin
      if (issue) begin
         pc_fifo[pf_wr] <= pc;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         pf_rd       <= '0;
         pf_wr       <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            ibuf_instr[i] <= '0;
            ibuf_pc[i]    <= '0;
         end
      end else begin
         if (issue) begin
            pf_wr <= pf_wr + PTR_W'(1);
         end
         if (imem_rvalid_i) begin
            pf_rd <= pf_rd + PTR_W'(1);
         end

         case ({issue, imem_rvalid_i})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase

         if (redirect_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc      <= redirect_pc_i & ~32'd3;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            discard <= outstanding - CNT_W'(imem_rvalid_i);
         end else begin
            if (issue) begin
               pc <= pc + 32'd4;
            end
            if (imem_rvalid_i && (discard != '0)) begin
               discard <= discard - CNT_W'(1);
            end
            if (keep) begin
               ibuf_instr[wr_ptr] <= imem_rdata_i;
               ibuf_pc[wr_ptr]    <= rsp_pc;
               wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (consume) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({keep, consume})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule
